// File: rtl/led_masked_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : led_masked_pkg                                                  |
// | Purpose : Shared constants, FSM state type and S-box table for the        |
// |           nibble-serial masked LED SubCells layer.                        |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package led_masked_pkg;

  localparam int NIBBLES  = 16;   // nibbles per 64-bit LED state
  localparam int SBOX_LAT = 3;    // S-box pipeline depth in cycles
  localparam int R_SBOX_W = 36;   // fresh randomness consumed by the S-box
  localparam int RS_W     = 8;    // width of the chained rs seed

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // PRESENT S-box, entry x at bits [4x+3:4x].
  localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;

  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    return SBOX_TBL[{x, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_subcells_serial_sbox.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : led_subcells_serial_sbox                                        |
// | Purpose : 3-share masked PRESENT S-box, 3-cycle pipeline, no reset.       |
// |           Output shares XOR to S(i_s1 ^ i_s2 ^ i_s3) of the nibble        |
// |           presented three cycles earlier; every stage is re-shared with   |
// |           fresh randomness.                                               |
// | Ports   : clk  - clock                                                    |
// |           i_en - nibble valid; stage 1 loads zero shares when low         |
// |           i_s1..3 - input shares, i_r - fresh randomness, i_rs - seed     |
// |           o_s1..3 - output shares, o_rs - next seed (combinational)       |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module led_subcells_serial_sbox
  import led_masked_pkg::*;
(
  input  logic                clk,
  input  logic                i_en,
  input  logic [3:0]          i_s1,
  input  logic [3:0]          i_s2,
  input  logic [3:0]          i_s3,
  input  logic [R_SBOX_W-1:0] i_r,
  input  logic [RS_W-1:0]     i_rs,
  output logic [3:0]          o_s1,
  output logic [3:0]          o_s2,
  output logic [3:0]          o_s3,
  output logic [RS_W-1:0]     o_rs
);

  logic [3:0] w_m0, w_m1, w_y;
  logic [3:0] r_a1, r_a2, r_a3;
  logic [3:0] r_b1, r_b2, r_b3;
  logic [3:0] r_c1, r_c2, r_c3;

  // Entry refresh masks mix the chained seed with this cycle's randomness.
  assign w_m0 = i_r[3:0] ^ i_rs[3:0];
  assign w_m1 = i_r[7:4] ^ i_rs[7:4];

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_a1 <= i_s1 ^ w_m0;
      r_a2 <= i_s2 ^ w_m1;
      r_a3 <= i_s3 ^ w_m0 ^ w_m1;
    end else begin
      r_a1 <= '0;
      r_a2 <= '0;
      r_a3 <= '0;
    end
  end

  // Nonlinear stage: result leaves as a fresh 3-sharing.
  assign w_y = present_sbox(r_a1 ^ r_a2 ^ r_a3);

  always_ff @(posedge clk) begin
    r_b1 <= w_y ^ i_r[11:8];
    r_b2 <= i_r[15:12];
    r_b3 <= i_r[11:8] ^ i_r[15:12];
  end

  always_ff @(posedge clk) begin
    r_c1 <= r_b1 ^ i_r[19:16];
    r_c2 <= r_b2 ^ i_r[23:20];
    r_c3 <= r_b3 ^ i_r[19:16] ^ i_r[23:20];
  end

  assign o_s1 = r_c1;
  assign o_s2 = r_c2;
  assign o_s3 = r_c3;

  // Seed chain: rotate and fold in the remaining randomness bits.
  assign o_rs = {i_rs[RS_W-2:0], i_rs[RS_W-1]} ^ i_r[31:24] ^ {2{i_r[35:32]}};

endmodule
`default_nettype wire

// File: rtl/led_subcells_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : led_subcells_serial                                             |
// | Purpose : Nibble-serial masked LED SubCells. Streams 16 nibbles of three  |
// |           shares through one masked S-box and reassembles the result.     |
// | Ports   : clk, rst (sync, active high), start (one-cycle request)         |
// |           state_in1..3 - input shares, r - [35:0] S-box, [43:36] seed     |
// |           state_out1..3 - result shares, busy, done (one-cycle pulse)     |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module led_subcells_serial
  import led_masked_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [63:0]              state_in1,
  input  logic [63:0]              state_in2,
  input  logic [63:0]              state_in3,
  input  logic [RS_W+R_SBOX_W-1:0] r,
  output logic [63:0]              state_out1,
  output logic [63:0]              state_out2,
  output logic [63:0]              state_out3,
  output logic                     busy,
  output logic                     done
);

  localparam logic [3:0] c_LAST_NIB  = 4'(NIBBLES - 1);
  localparam logic [1:0] c_LAST_DRN  = 2'(SBOX_LAT - 1);
  localparam logic [3:0] c_FIRST_CAP = 4'(SBOX_LAT);

  state_t          r_state, w_next;
  logic [63:0]     r_sh1, r_sh2, r_sh3;
  logic [3:0]      r_nib;
  logic [1:0]      r_drn;
  logic [RS_W-1:0] r_rs;

  logic            w_accept, w_capture, w_en;
  logic [RS_W-1:0] w_rs_in, w_rs_out;
  logic [3:0]      w_y1, w_y2, w_y3;

  assign w_accept = start && (r_state == IDLE || r_state == DONE);

  // Nibble k emerges SBOX_LAT cycles after it was fed, so the capture window
  // is FEED cycles SBOX_LAT..15 plus the whole DRAIN phase (16 captures).
  assign w_capture = (r_state == FEED && r_nib >= c_FIRST_CAP) || (r_state == DRAIN);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, DONE: w_next = w_accept ? FEED : IDLE;
      FEED:       w_next = (r_nib == c_LAST_NIB) ? DRAIN : FEED;
      DRAIN:      w_next = (r_drn == c_LAST_DRN) ? DONE : DRAIN;
      default:    w_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    w_en    = 1'b0;
    w_rs_in = r_rs;
    unique case (r_state)
      FEED: begin
        busy = 1'b1;
        w_en = 1'b1;
        // First nibble of a run takes its seed from the external input.
        if (r_nib == 4'd0) w_rs_in = r[RS_W+R_SBOX_W-1:R_SBOX_W];
      end
      DRAIN:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: input shift registers, counters, seed register, result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh1      <= '0;
      r_sh2      <= '0;
      r_sh3      <= '0;
      r_nib      <= '0;
      r_drn      <= '0;
      r_rs       <= '0;
      state_out1 <= '0;
      state_out2 <= '0;
      state_out3 <= '0;
    end else begin
      r_rs <= w_rs_out;
      if (w_accept) begin
        r_sh1 <= state_in1;
        r_sh2 <= state_in2;
        r_sh3 <= state_in3;
        r_nib <= '0;
        r_drn <= '0;
      end else if (r_state == FEED) begin
        r_sh1 <= {4'h0, r_sh1[63:4]};
        r_sh2 <= {4'h0, r_sh2[63:4]};
        r_sh3 <= {4'h0, r_sh3[63:4]};
        r_nib <= r_nib + 4'd1;
      end else if (r_state == DRAIN) begin
        r_drn <= r_drn + 2'd1;
      end
      // Shift in from the top so nibble 0 ends up in bits [3:0].
      if (w_capture) begin
        state_out1 <= {w_y1, state_out1[63:4]};
        state_out2 <= {w_y2, state_out2[63:4]};
        state_out3 <= {w_y3, state_out3[63:4]};
      end
    end
  end

  led_subcells_serial_sbox u_sbox (
    .clk  (clk),
    .i_en (w_en),
    .i_s1 (r_sh1[3:0]),
    .i_s2 (r_sh2[3:0]),
    .i_s3 (r_sh3[3:0]),
    .i_r  (r[R_SBOX_W-1:0]),
    .i_rs (w_rs_in),
    .o_s1 (w_y1),
    .o_s2 (w_y2),
    .o_s3 (w_y3),
    .o_rs (w_rs_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_led_subcells_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_led_subcells_serial                                          |
// | Purpose : Self-checking bench for led_subcells_serial. Expected results   |
// |           are queued when a run is started and compared at done.          |
// | Rev     : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_led_subcells_serial;

  localparam logic [63:0] PT  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CT  = 64'hC56B_90AD_3EF8_4712;
  localparam logic [63:0] ZCT = 64'hCCCC_CCCC_CCCC_CCCC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [63:0] state_in1 = '0, state_in2 = '0, state_in3 = '0;
  logic [43:0] r = '0;
  logic [63:0] state_out1, state_out2, state_out3;
  logic        busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  bit          rand_r = 1'b0;

  led_subcells_serial dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .state_in1  (state_in1),
    .state_in2  (state_in2),
    .state_in3  (state_in3),
    .r          (r),
    .state_out1 (state_out1),
    .state_out2 (state_out2),
    .state_out3 (state_out3),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] out_xor();
    return state_out1 ^ state_out2 ^ state_out3;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic [63:0] t;
    @(posedge clk);
    #1;
    if (rand_r) begin
      t = {$urandom(), $urandom()};
      r = t[43:0];
    end
  endtask

  // Drive one start pulse; optionally queue the result the run must produce.
  task automatic go(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                    input bit push, input logic [63:0] expv, input string tag);
    state_in1 = a;
    state_in2 = b;
    state_in3 = c;
    start     = 1'b1;
    if (push) exp_q.push_back(expv);
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 64'(busy), 64'd1);
  endtask

  // Wait for done counting cycles (start cycle = 0); optional ignored start.
  task automatic wait_done(input string tag, input int inject_at);
    int          n;
    bit          seen;
    logic [63:0] e;
    n    = 1;
    seen = done;
    while (!seen && n < 40) begin
      if (n == inject_at) begin
        state_in1 = '1;
        start     = 1'b1;
      end
      tick();
      start = 1'b0;
      n++;
      seen = done;
    end
    check({tag, " done latency"}, 64'(n), 64'd20);
    if (seen) begin
      check({tag, " busy in DONE"}, 64'(busy), 64'd0);
      check({tag, " scoreboard depth"}, 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, " output xor"}, out_xor(), e);
      end
    end
  endtask

  // Idle for a while: no done, no busy, outputs held.
  task automatic quiet(input string tag, input logic [63:0] hold);
    int n_done = 0;
    int n_busy = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check({tag, " extra done pulses"}, 64'(n_done), 64'd0);
    check({tag, " busy while idle"}, 64'(n_busy), 64'd0);
    check({tag, " outputs held"}, out_xor(), hold);
  endtask

  initial begin
    logic [63:0] s2, s3;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset out1", state_out1, 64'd0);
    check("reset out2", state_out2, 64'd0);
    check("reset out3", state_out3, 64'd0);

    // Unmasked plaintext, zero randomness
    go(PT, 64'd0, 64'd0, 1'b1, CT, "plain");
    wait_done("plain", 0);
    quiet("plain idle", CT);

    // Random sharing with fresh randomness every cycle
    rand_r = 1'b1;
    s2 = {$urandom(), $urandom()};
    s3 = {$urandom(), $urandom()};
    go(PT ^ s2 ^ s3, s2, s3, 1'b1, CT, "shared");
    wait_done("shared", 0);

    // Start during FEED cycle 5 must be ignored
    s2 = {$urandom(), $urandom()};
    s3 = {$urandom(), $urandom()};
    go(PT ^ s2 ^ s3, s2, s3, 1'b1, CT, "restart ignored");
    wait_done("restart ignored", 6);
    quiet("restart ignored idle", CT);

    // Reset during FEED cycle 10 aborts the run
    go(PT ^ s2 ^ s3, s2, s3, 1'b0, 64'd0, "abort");
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort out1", state_out1, 64'd0);
    check("abort out2", state_out2, 64'd0);
    check("abort out3", state_out3, 64'd0);
    quiet("abort idle", 64'd0);
    s2 = {$urandom(), $urandom()};
    s3 = {$urandom(), $urandom()};
    go(PT ^ s2 ^ s3, s2, s3, 1'b1, CT, "after abort");
    wait_done("after abort", 0);

    // Back-to-back: start in the DONE cycle with all-zero shares
    s2 = {$urandom(), $urandom()};
    s3 = {$urandom(), $urandom()};
    go(PT ^ s2 ^ s3, s2, s3, 1'b1, CT, "b2b first");
    wait_done("b2b first", 0);
    go(64'd0, 64'd0, 64'd0, 1'b1, ZCT, "b2b second");
    wait_done("b2b second", 0);

    // start and rst together: reset wins
    state_in1 = PT;
    start     = 1'b1;
    rst       = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    check("start+rst busy", 64'(busy), 64'd0);
    check("start+rst out1", state_out1, 64'd0);
    quiet("start+rst idle", 64'd0);

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_subcells_serial.md
LED_SUBCELLS_SERIAL -- requirements
Module: led_subcells_serial

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock for all state.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  one-cycle request to run SubCells on the loaded state.
REQ-004 SHALL have: state_in1 / state_in2 / state_in3  in  64 each  shares 0/1/2 of the LED state; nibble i = bits [4i+3:4i].
REQ-005 SHALL have: r  in  44  fresh randomness per cycle: [35:0] to the S-box, [43:36] as the rs seed.
REQ-006 SHALL have: state_out1 / state_out2 / state_out3  out  64 each  shares of the substituted state.
REQ-007 SHALL have: busy  out  1  high from the cycle after start is accepted until done.
REQ-008 SHALL have: done  out  1  one-cycle pulse; state_out* valid from this cycle until the next accepted start or reset.

Function
REQ-009 SHALL be a nibble-serial SubCells layer feeding one 3-share masked PRESENT S-box with fixed latency SBOX_LAT = 3 cycles.
REQ-010 SHALL use FSM states IDLE, FEED, DRAIN, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; when accepted, it SHALL latch state_in1..3 into three 64-bit shift registers and enter FEED; start in FEED or DRAIN SHALL be ignored.
REQ-012 In FEED, it SHALL present nibble k = 0..15 (LSB nibble first) of each share to the S-box on FEED cycle k, with S-box EN = 1.
REQ-013 It SHALL leave FEED after 16 cycles and enter DRAIN for SBOX_LAT cycles with EN = 0.
REQ-014 It SHALL capture the S-box output for nibble k exactly SBOX_LAT cycles after presentation, via a 4-bit-per-share shift-in from the MSB, so that nibble k lands at bits [4k+3:4k] after 16 captures.
REQ-015 On the cycle a nibble is presented, rs_in SHALL be r[43:36] for nibble 0 and the rs_out registered one cycle earlier for nibbles 1..15.
REQ-016 It SHALL pass r[35:0] to the S-box unmodified on every cycle, whatever the state.
REQ-017 DONE SHALL last exactly one cycle, with done = 1 and busy = 0; with no start in that cycle, the next state SHALL be IDLE.
REQ-018 done SHALL assert exactly 20 cycles after the clock edge that sampled the accepted start.
REQ-019 The block SHALL never combine shares of one variable outside the S-box: no XOR across state_in1/2/3 and no cross-share mux select.
REQ-020 state_out* SHALL hold their value from DONE through IDLE and SHALL update only by capture during a run.
REQ-021 start asserted in DONE SHALL begin a new run with no idle cycle; the DONE-cycle outputs SHALL remain visible during that DONE cycle.

Reset
REQ-022 rst SHALL force IDLE, busy = 0, done = 0, state_out1..3 = 0, input shift registers = 0 and the rs register = 0 on the next edge.
REQ-023 rst SHALL take priority over start.
REQ-024 rst asserted in FEED or DRAIN SHALL abort the run, produce no done pulse and discard partial captures.
REQ-025 The S-box pipeline registers need no reset; any outputs still in flight after an aborted run SHALL NOT be captured.

Structure
REQ-026 Package led_masked_pkg SHALL hold NIBBLES = 16, SBOX_LAT = 3, R_SBOX_W = 36, RS_W = 8 and the FSM state enum.
REQ-027 There SHALL be a single sub-module, the existing 3-share masked PRESENT S-box, instantiated once.
REQ-028 The nibble counter SHALL be 4 bits and the drain counter 2 bits, with no wider arithmetic.

Verification
REQ-029 Bench SHALL drive state_in1 = 0x0123456789ABCDEF, state_in2 = state_in3 = 0, r = 0, start; XOR of the outputs at done SHALL equal 0xC56B90AD3EF84712.
REQ-030 Bench SHALL use the same plaintext split into random shares, with random r every cycle; the output XOR SHALL be 0xC56B90AD3EF84712 and done SHALL assert at cycle +20.
REQ-031 Bench SHALL pulse start again at FEED cycle 5; it SHALL be ignored, with a single done at +20 and a correct result.
REQ-032 Bench SHALL assert rst at FEED cycle 10; it SHALL reach IDLE next cycle with state_out* = 0 and no done, and a fresh start SHALL then give the correct result.
REQ-033 Bench SHALL assert start in the DONE cycle with all-zero shares; the second done SHALL come 20 cycles later, with output XOR = 0xCCCCCCCCCCCCCCCC.
REQ-034 Bench SHALL assert start and rst in the same cycle; rst SHALL win, busy SHALL stay 0 and no done SHALL occur.
